framebuffer_scanout: RTL and testbench
======================================

Name: framebuffer_scanout

Overview:
- Read side of the framebuffer.
- The rasterizer writes pixels into the framebuffer; this block reads them back in raster order, one pixel per clock.
- It generates display timing (hsync, vsync, data-enable) and presents aligned pixel data to the display PHY.
- It supports double buffering: the buffer select is latched once per frame, at the start of vertical blanking, so frame swaps never tear.

Parameters:
- DISPLAY_WIDTH, 100, active pixels per line
- DISPLAY_HEIGHT, 100, active lines per frame
- H_FRONT, 4, horizontal front porch (clocks)
- H_SYNC, 8, hsync pulse width (clocks)
- H_BACK, 4, horizontal back porch (clocks)
- V_FRONT, 2, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 2, vertical back porch (lines)
- SYNC_ACTIVE_HIGH, 0, sync polarity: 0 = syncs asserted low
- FRAMEBUFFER_DATA_BITS, 16, pixel width (RGB565)
- FRAMEBUFFER_SIZE, DISPLAY_WIDTH*DISPLAY_HEIGHT, words per buffer
- FRAMEBUFFER_ADDR_BITS, $clog2(2*FRAMEBUFFER_SIZE), read address width covering both buffers

Ports:
- clk  in  1  pixel clock; all logic on posedge
- rst  in  1  asynchronous, active-low reset
- enable  in  1  0 forces pixel_data to 0; timing keeps running
- buffer_sel  in  1  buffer to display next frame (0: base 0, 1: base FRAMEBUFFER_SIZE)
- framebuffer_rd_en  out  1  read strobe
- framebuffer_rd_addr  out  FRAMEBUFFER_ADDR_BITS  read address
- framebuffer_rd_data  in  FRAMEBUFFER_DATA_BITS  registered memory output, valid 1 clk after address
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- data_enable  out  1  active-video qualifier
- pixel_data  out  FRAMEBUFFER_DATA_BITS  pixel; 0 when data_enable low
- frame_done  out  1  one-clk pulse at start of vertical blanking
- displayed_buffer  out  1  currently latched buffer select

Behaviour:
- Timing totals: H_TOTAL = W+H_FRONT+H_SYNC+H_BACK; V_TOTAL = H+V_FRONT+V_SYNC+V_BACK.
- Counters: h_cnt runs 0..H_TOTAL-1 and wraps to 0; v_cnt increments on each h wrap and wraps from V_TOTAL-1 to 0.
- Stage 0, position (h,v):
  - active = h<W && v<H.
  - hsync_raw asserted for W+H_FRONT <= h < W+H_FRONT+H_SYNC.
  - vsync_raw asserted for H+V_FRONT <= v < H+V_FRONT+V_SYNC.
  - framebuffer_rd_en and framebuffer_rd_addr are registered from stage 0.
  - Address = latched_base + v*W + h when active; otherwise rd_en=0 and the address holds its last value.
- Stage 1: memory returns the data; active/hsync/vsync are delayed one register stage to stay aligned with it.
- Stage 2 (outputs): hsync, vsync, data_enable and pixel_data are all registered.
  - pixel_data = framebuffer_rd_data if delayed active && enable, else 0.
  - Sync polarity follows SYNC_ACTIVE_HIGH.
- Latency: every output appears exactly 2 clks after the counter reaches the corresponding position. rd_addr leads pixel_data by 2 clks.
- Buffer latch: at (h=0, v=H) the block latches buffer_sel into displayed_buffer and drives frame_done high for exactly one clk (visible 1 clk later, registered).
  - latched_base = displayed_buffer ? FRAMEBUFFER_SIZE : 0.
  - Changes to buffer_sel at any other time have no effect until the next latch point.
- Address arithmetic uses unsigned values of at least FRAMEBUFFER_ADDR_BITS. v*W is computed as an incrementing line-base register (+W per active line), not with a multiplier.
- Reset (rst low, async): counters=0, line base=0, displayed_buffer=0, rd_en=0, rd_addr=0, data_enable=0, pixel_data=0, frame_done=0; hsync/vsync at inactive level; pipeline cleared.
  - After release, the first posedge processes position (0,0), and pixel (0,0) is output 2 clks later.
  - Reset asserted mid-line or mid-frame aborts immediately. No partial-frame state survives.
- Boundary: the last active pixel (W-1,H-1) reads address base+W*H-1. The next read after wrap is base+0, using the newly latched buffer.

Test Plan (params W=4, H=3, H_FRONT=1, H_SYNC=2, H_BACK=1, V_FRONT=1, V_SYNC=1, V_BACK=1; H_TOTAL=8, V_TOTAL=6, 48 clks/frame):
- Reset release with fb[i]=i+1 -> rd_addr sequence 0,1,2,3 in cycles 0-3 of each line; pixel_data 1,2,3,4 with data_enable high on cycles 2-5; rows 0-2 give values 1..12.
- Sync timing -> hsync low (SYNC_ACTIVE_HIGH=0) for output cycles h=5,6 of every line; vsync low for all of line v=4; data_enable low on lines 3-5.
- Latch point: buffer_sel=1 held from reset; fb[12+i]=100+i -> frame_done pulses once at clk 24+1; the next frame outputs pixels 100..111 with rd_addr 12..23; displayed_buffer=1.
- buffer_sel toggled mid-frame at clk 10, then back at clk 12 -> no address change in the current frame; the value sampled at the latch point decides the next frame.
- enable=0 during line 1 -> pixel_data=0 while data_enable still pulses 4 clks; timing unchanged.
- Async reset asserted at clk 19 (mid line 2) -> all outputs at reset values without waiting for a clock edge; after release, rd_addr restarts at 0 and frame_done stays 0 until clk 24 of the new frame.

Source files
------------

// File: rtl/framebuffer_scanout_if.sv
// Framebuffer read port: scanout drives address/strobe, memory returns
// registered data one clock later.
interface framebuffer_scanout_if #(
   parameter int ADDR_BITS = 15,
   parameter int DATA_BITS = 16
) ();
   logic                 framebuffer_rd_en;
   logic [ADDR_BITS-1:0] framebuffer_rd_addr;
   logic [DATA_BITS-1:0] framebuffer_rd_data;

   modport master (
      output framebuffer_rd_en,
      output framebuffer_rd_addr,
      input  framebuffer_rd_data
   );

   modport slave (
      input  framebuffer_rd_en,
      input  framebuffer_rd_addr,
      output framebuffer_rd_data
   );
endinterface

// File: rtl/framebuffer_scanout.sv
// Raster-order framebuffer reader with display timing generation and
// tear-free double-buffer selection latched at the start of vertical blanking.
module framebuffer_scanout #(
   parameter int DISPLAY_WIDTH         = 100,
   parameter int DISPLAY_HEIGHT        = 100,
   parameter int H_FRONT               = 4,
   parameter int H_SYNC                = 8,
   parameter int H_BACK                = 4,
   parameter int V_FRONT               = 2,
   parameter int V_SYNC                = 2,
   parameter int V_BACK                = 2,
   parameter int SYNC_ACTIVE_HIGH      = 0,
   parameter int FRAMEBUFFER_DATA_BITS = 16,
   parameter int FRAMEBUFFER_SIZE      = DISPLAY_WIDTH * DISPLAY_HEIGHT,
   parameter int FRAMEBUFFER_ADDR_BITS = $clog2(2 * FRAMEBUFFER_SIZE)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             enable,
   input  logic                             buffer_sel,
   framebuffer_scanout_if.master            fb_rd,
   output logic                             hsync,
   output logic                             vsync,
   output logic                             data_enable,
   output logic [FRAMEBUFFER_DATA_BITS-1:0] pixel_data,
   output logic                             frame_done,
   output logic                             displayed_buffer
);

   localparam int H_TOTAL = DISPLAY_WIDTH + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = DISPLAY_HEIGHT + V_FRONT + V_SYNC + V_BACK;
   // One spare bit so the exclusive end-of-range constants always fit.
   localparam int HW = $clog2(H_TOTAL + 1);
   localparam int VW = $clog2(V_TOTAL + 1);
   localparam int AW = FRAMEBUFFER_ADDR_BITS;
   localparam int DW = FRAMEBUFFER_DATA_BITS;

   localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT_END    = HW'(DISPLAY_WIDTH);
   localparam logic [HW-1:0] H_SYNC_START = HW'(DISPLAY_WIDTH + H_FRONT);
   localparam logic [HW-1:0] H_SYNC_END   = HW'(DISPLAY_WIDTH + H_FRONT + H_SYNC);
   localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT_END    = VW'(DISPLAY_HEIGHT);
   localparam logic [VW-1:0] V_SYNC_START = VW'(DISPLAY_HEIGHT + V_FRONT);
   localparam logic [VW-1:0] V_SYNC_END   = VW'(DISPLAY_HEIGHT + V_FRONT + V_SYNC);
   localparam logic [AW-1:0] LINE_STEP    = AW'(DISPLAY_WIDTH);
   localparam logic [AW-1:0] BUF1_BASE    = AW'(FRAMEBUFFER_SIZE);
   localparam logic          SYNC_ON      = (SYNC_ACTIVE_HIGH != 0);

   // Stage 0: raster position and line base
   logic [HW-1:0] h_cnt_q, h_cnt_d;
   logic [VW-1:0] v_cnt_q, v_cnt_d;
   logic [AW-1:0] line_base_q, line_base_d;
   logic          displayed_buffer_q, displayed_buffer_d;
   logic          frame_done_q, frame_done_d;

   // Stage 1: registered read request and aligned timing
   logic          rd_en_q, rd_en_d;
   logic [AW-1:0] rd_addr_q, rd_addr_d;
   logic          act_s1_q, hs_s1_q, vs_s1_q;

   // Stage 2: timing aligned with returned memory data
   logic          act_s2_q, hs_s2_q, vs_s2_q;

   // Output registers
   logic          hsync_q, hsync_d;
   logic          vsync_q, vsync_d;
   logic          data_enable_q;
   logic [DW-1:0] pixel_data_q, pixel_data_d;

   logic          active, hs_raw, vs_raw, latch_pt;
   logic [AW-1:0] latched_base;

   always_comb begin
      // NOTE: every variable gets a default before any branch so no path leaves
      // it unassigned; an unassigned path would infer a latch.
      h_cnt_d            = h_cnt_q + HW'(1);
      v_cnt_d            = v_cnt_q;
      line_base_d        = line_base_q;
      displayed_buffer_d = displayed_buffer_q;

      active   = (h_cnt_q < H_ACT_END) && (v_cnt_q < V_ACT_END);
      hs_raw   = (h_cnt_q >= H_SYNC_START) && (h_cnt_q < H_SYNC_END);
      vs_raw   = (v_cnt_q >= V_SYNC_START) && (v_cnt_q < V_SYNC_END);
      latch_pt = (h_cnt_q == '0) && (v_cnt_q == V_ACT_END);

      if (h_cnt_q == H_LAST) begin
         h_cnt_d = '0;
         if (v_cnt_q == V_LAST) begin
            v_cnt_d     = '0;
            line_base_d = '0;
         end else begin
            v_cnt_d = v_cnt_q + VW'(1);
            if (v_cnt_q < V_ACT_END) line_base_d = line_base_q + LINE_STEP;
         end
      end

      // Buffer select only takes effect here, so a frame never mixes buffers.
      if (latch_pt) displayed_buffer_d = buffer_sel;
      frame_done_d = latch_pt;

      latched_base = displayed_buffer_q ? BUF1_BASE : '0;
      rd_en_d      = active;
      rd_addr_d    = active ? (latched_base + line_base_q + AW'(h_cnt_q)) : rd_addr_q;

      pixel_data_d = (act_s2_q && enable) ? fb_rd.framebuffer_rd_data : '0;
      hsync_d      = SYNC_ON ? hs_s2_q : ~hs_s2_q;
      vsync_d      = SYNC_ON ? vs_s2_q : ~vs_s2_q;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, keeping the pipeline stages independent of order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         h_cnt_q            <= '0;
         v_cnt_q            <= '0;
         line_base_q        <= '0;
         displayed_buffer_q <= 1'b0;
         frame_done_q       <= 1'b0;
         rd_en_q            <= 1'b0;
         rd_addr_q          <= '0;
         act_s1_q           <= 1'b0;
         hs_s1_q            <= 1'b0;
         vs_s1_q            <= 1'b0;
         act_s2_q           <= 1'b0;
         hs_s2_q            <= 1'b0;
         vs_s2_q            <= 1'b0;
         hsync_q            <= ~SYNC_ON;
         vsync_q            <= ~SYNC_ON;
         data_enable_q      <= 1'b0;
         pixel_data_q       <= '0;
      end else begin
         h_cnt_q            <= h_cnt_d;
         v_cnt_q            <= v_cnt_d;
         line_base_q        <= line_base_d;
         displayed_buffer_q <= displayed_buffer_d;
         frame_done_q       <= frame_done_d;
         rd_en_q            <= rd_en_d;
         rd_addr_q          <= rd_addr_d;
         act_s1_q           <= active;
         hs_s1_q            <= hs_raw;
         vs_s1_q            <= vs_raw;
         act_s2_q           <= act_s1_q;
         hs_s2_q            <= hs_s1_q;
         vs_s2_q            <= vs_s1_q;
         hsync_q            <= hsync_d;
         vsync_q            <= vsync_d;
         data_enable_q      <= act_s2_q;
         pixel_data_q       <= pixel_data_d;
      end
   end

   assign fb_rd.framebuffer_rd_en   = rd_en_q;
   assign fb_rd.framebuffer_rd_addr = rd_addr_q;
   assign hsync                     = hsync_q;
   assign vsync                     = vsync_q;
   assign data_enable               = data_enable_q;
   assign pixel_data                = pixel_data_q;
   assign frame_done                = frame_done_q;
   assign displayed_buffer          = displayed_buffer_q;

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Scoreboard bench for framebuffer_scanout on a 4x3 display: a position
// model predicts reads and queues the pixel/timing output due two clocks later.
module tb_framebuffer_scanout;

   localparam int W     = 4;
   localparam int H     = 3;
   localparam int HF    = 1;
   localparam int HS    = 2;
   localparam int HB    = 1;
   localparam int VF    = 1;
   localparam int VS    = 1;
   localparam int VB    = 1;
   localparam int HT    = W + HF + HS + HB;
   localparam int VT    = H + VF + VS + VB;
   localparam int FSIZE = W * H;
   localparam int AW    = $clog2(2 * FSIZE);
   localparam int DW    = 16;

   typedef struct {
      logic          de;
      logic          hs;
      logic          vs;
      logic [DW-1:0] pix_raw;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          enable;
   logic          buffer_sel;
   logic          hsync, vsync, data_enable, frame_done, displayed_buffer;
   logic [DW-1:0] pixel_data;

   logic [DW-1:0] fb_mem [0:2*FSIZE-1];
   exp_t          exp_q[$];

   int            checks   = 0;
   int            failures = 0;
   int            cycle    = 0;
   int            pos;
   logic          disp_m;
   logic [AW-1:0] addr_m;

   framebuffer_scanout_if #(.ADDR_BITS(AW), .DATA_BITS(DW)) fb_bus ();

   framebuffer_scanout #(
      .DISPLAY_WIDTH(W), .DISPLAY_HEIGHT(H),
      .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .SYNC_ACTIVE_HIGH(0), .FRAMEBUFFER_DATA_BITS(DW)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .enable           (enable),
      .buffer_sel       (buffer_sel),
      .fb_rd            (fb_bus),
      .hsync            (hsync),
      .vsync            (vsync),
      .data_enable      (data_enable),
      .pixel_data       (pixel_data),
      .frame_done       (frame_done),
      .displayed_buffer (displayed_buffer)
   );

   always #5 clk = ~clk;

   // Registered memory: data valid one clock after the address
   always @(posedge clk)
      if (fb_bus.framebuffer_rd_en) fb_bus.framebuffer_rd_data <= fb_mem[fb_bus.framebuffer_rd_addr];

   task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("FAIL %s cycle=%0d actual=0x%0h expected=0x%0h", tag, cycle, actual, expected);
      end
   endtask

   task automatic reset_model();
      exp_t idle;
      idle.de      = 1'b0;
      idle.hs      = 1'b0;
      idle.vs      = 1'b0;
      idle.pix_raw = '0;
      exp_q.delete();
      exp_q.push_back(idle);
      exp_q.push_back(idle);
      pos    = 0;
      disp_m = 1'b0;
      addr_m = '0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rd_en"},   32'(fb_bus.framebuffer_rd_en), 32'd0);
      check({tag, "_rd_addr"}, 32'(fb_bus.framebuffer_rd_addr), 32'd0);
      check({tag, "_de"},      32'(data_enable), 32'd0);
      check({tag, "_pixel"},   32'(pixel_data), 32'd0);
      check({tag, "_hsync"},   32'(hsync), 32'd1);
      check({tag, "_vsync"},   32'(vsync), 32'd1);
      check({tag, "_fdone"},   32'(frame_done), 32'd0);
      check({tag, "_dispbuf"}, 32'(displayed_buffer), 32'd0);
   endtask

   // One clock: model the position processed at this edge, queue its output,
   // pop the output due now, then compare on the falling edge.
   task automatic step();
      int            h, v;
      logic          act, fd_exp, en_m;
      exp_t          e, o;
      logic [DW-1:0] pix_exp;
      @(posedge clk);
      h   = pos % HT;
      v   = pos / HT;
      act = (h < W) && (v < H);
      if (act) addr_m = AW'((disp_m ? FSIZE : 0) + v * W + h);
      fd_exp = (h == 0) && (v == H);
      if (fd_exp) disp_m = buffer_sel;
      e.de      = act;
      e.hs      = (h >= W + HF) && (h < W + HF + HS);
      e.vs      = (v >= H + VF) && (v < H + VF + VS);
      e.pix_raw = act ? fb_mem[addr_m] : '0;
      exp_q.push_back(e);
      o    = exp_q.pop_front();
      en_m = enable;
      pos  = (pos + 1) % (HT * VT);
      @(negedge clk);
      pix_exp = (o.de && en_m) ? o.pix_raw : '0;
      check("rd_en",    32'(fb_bus.framebuffer_rd_en), 32'(act));
      check("rd_addr",  32'(fb_bus.framebuffer_rd_addr), 32'(addr_m));
      check("fdone",    32'(frame_done), 32'(fd_exp));
      check("dispbuf",  32'(displayed_buffer), 32'(disp_m));
      check("de",       32'(data_enable), 32'(o.de));
      check("hsync",    32'(hsync), 32'(!o.hs));
      check("vsync",    32'(vsync), 32'(!o.vs));
      check("pixel",    32'(pixel_data), 32'(pix_exp));
      cycle++;
   endtask

   initial begin
      for (int i = 0; i < FSIZE; i++) begin
         fb_mem[i]         = DW'(i + 1);
         fb_mem[FSIZE + i] = DW'(100 + i);
      end
      rst        = 1'b1;
      enable     = 1'b1;
      buffer_sel = 1'b1;

      #2 rst = 1'b0;
      #1 check_reset_outputs("por");
      reset_model();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;

      // Frame 0 shows buffer 0; buffer_sel=1 is latched at its blanking start
      repeat (HT * VT) step();

      // Frame 1 shows buffer 1; a brief mid-frame toggle must not matter
      for (int i = 0; i < HT * VT; i++) begin
         if (i == 10) buffer_sel = 1'b0;
         if (i == 12) buffer_sel = 1'b1;
         step();
      end

      // Frame 2 still buffer 1; select buffer 0 before its latch point
      for (int i = 0; i < HT * VT; i++) begin
         if (i == 20) buffer_sel = 1'b0;
         step();
      end

      // Frame 3 shows buffer 0; enable dropped across output of line 1
      for (int i = 0; i < HT * VT; i++) begin
         if (i == 10) enable = 1'b0;
         if (i == 18) enable = 1'b1;
         step();
      end

      // Frame 4: async reset mid line 2, then a fresh frame
      buffer_sel = 1'b1;
      repeat (19) step();
      #2 rst = 1'b0;
      #1 check_reset_outputs("async");
      reset_model();
      @(negedge clk);
      check_reset_outputs("held");
      rst = 1'b1;
      repeat (HT * VT + 12) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
